// File: rtl/flex_counter_pro.sv
// ---------------------------------------------------------------------------
// flex_counter_pro
//
// Purpose:
//   Up/down counter whose step is gated by a programmable prescaler. The
//   count runs through 1..rollover_val. It can wrap around at the terminal
//   value, or it can stop there and raise a sticky done flag (one-shot mode).
//   Every output comes straight from a register.
//
// Parameters:
//   NUM_CNT_BITS   width of count_out, rollover_val and load_val
//   PRESCALE_BITS  width of prescale_val and the internal prescale counter
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   rst            synchronous active-high reset (highest priority)
//   clear          synchronous clear of count, prescaler, done and wrap_pulse
//   load           synchronous load of load_val into the count
//   load_val       value taken on load (not range checked)
//   count_enable   qualifies advance of the prescaler
//   count_dir      0 = count up, 1 = count down
//   oneshot        0 = wrap at terminal, 1 = stop at terminal and set done
//   rollover_val   upper bound of the count range (0 suppresses stepping)
//   prescale_val   a step occurs every prescale_val+1 enabled cycles
//   count_out      registered count
//   rollover_flag  registered, high while count_out equals the terminal
//   wrap_pulse     registered one-cycle pulse after each wrap
//   done           registered sticky one-shot completion flag
// ---------------------------------------------------------------------------
module flex_counter_pro #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     count_enable,
    input  logic                     count_dir,
    input  logic                     oneshot,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     wrap_pulse,
    output logic                     done
);

    localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = '0;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] prescale_cnt;
    logic [PRESCALE_BITS-1:0] prescale_next;
    logic [NUM_CNT_BITS-1:0]  count_next;
    logic [NUM_CNT_BITS-1:0]  stepped_cnt;
    logic [NUM_CNT_BITS-1:0]  terminal;
    logic                     would_wrap;
    logic                     step_due;
    logic                     done_next;
    logic                     wrap_next;
    logic                     flag_next;

    // The terminal value depends on the direction. Up-counting ends at
    // rollover_val. Down-counting ends at 1, because the range is 1..rollover_val.
    always_comb begin
        terminal = count_dir ? CNT_ONE : rollover_val;
    end

    // Candidate value for a step, and whether that step leaves the range.
    // A loaded value above rollover_val also counts as a wrap in either direction.
    always_comb begin
        stepped_cnt = count_out;
        would_wrap  = 1'b0;
        if (!count_dir) begin
            if (count_out >= rollover_val) begin
                stepped_cnt = CNT_ONE;
                would_wrap  = 1'b1;
            end else begin
                stepped_cnt = count_out + CNT_ONE;
            end
        end else begin
            if ((count_out <= CNT_ONE) || (count_out > rollover_val)) begin
                stepped_cnt = rollover_val;
                would_wrap  = 1'b1;
            end else begin
                stepped_cnt = count_out - CNT_ONE;
            end
        end
    end

    // Prescaler. It advances only on enabled cycles. It freezes while done is
    // set, so that after a load or clear the counting restarts from a known phase.
    always_comb begin
        step_due      = 1'b0;
        prescale_next = prescale_cnt;
        if (count_enable && !done) begin
            if (prescale_cnt == prescale_val) begin
                step_due      = 1'b1;
                prescale_next = PRE_ZERO;
            end else begin
                prescale_next = prescale_cnt + PRE_ONE;
            end
        end
    end

    // Next-state selection in priority order clear > load > step > hold
    // (rst is applied in the register block). When clear or load wins, any
    // step due in the same cycle is dropped. When rollover_val is zero, steps
    // are suppressed but the prescaler keeps running.
    always_comb begin
        count_next = count_out;
        done_next  = done;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = CNT_ZERO;
            done_next  = 1'b0;
        end else if (load) begin
            count_next = load_val;
            done_next  = 1'b0;
        end else if (step_due && (rollover_val != CNT_ZERO)) begin
            if (would_wrap && oneshot) begin
                done_next = 1'b1;
            end else begin
                count_next = stepped_cnt;
                wrap_next  = would_wrap;
            end
        end
        flag_next = (count_next == terminal);
    end

    // State register. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out     <= CNT_ZERO;
            prescale_cnt  <= PRE_ZERO;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
            done          <= 1'b0;
        end else begin
            count_out     <= count_next;
            prescale_cnt  <= (clear || load) ? PRE_ZERO : prescale_next;
            rollover_flag <= flag_next;
            wrap_pulse    <= wrap_next;
            done          <= done_next;
        end
    end

endmodule

// File: tb/tb_flex_counter_pro.sv
// ---------------------------------------------------------------------------
// tb_flex_counter_pro
//
// Directed-vector bench for flex_counter_pro (default 4-bit widths).
// The stimulus process drives one cycle at a time. It pushes the
// hand-computed post-edge outputs into a queue. The monitor process pops
// entries on the following falling edge and compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_flex_counter_pro;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       count_enable;
    logic       count_dir;
    logic       oneshot;
    logic [3:0] rollover_val;
    logic [3:0] prescale_val;
    logic [3:0] count_out;
    logic       rollover_flag;
    logic       wrap_pulse;
    logic       done;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       flag;
        logic       wrap;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    flex_counter_pro #(
        .NUM_CNT_BITS (4),
        .PRESCALE_BITS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_dir    (count_dir),
        .oneshot      (oneshot),
        .rollover_val (rollover_val),
        .prescale_val (prescale_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_pulse   (wrap_pulse),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, let the edge happen, queue the expected result.
    task automatic apply_stimulus(input string name, input logic r, input logic c,
                                  input logic l, input logic [3:0] lv, input logic en,
                                  input logic [3:0] e_cnt, input logic e_flag,
                                  input logic e_wrap, input logic e_done);
        exp_t e;
        rst          = r;
        clear        = c;
        load         = l;
        load_val     = lv;
        count_enable = en;
        @(posedge clk);
        e.name = name;
        e.cnt  = e_cnt;
        e.flag = e_flag;
        e.wrap = e_wrap;
        e.dn   = e_done;
        exp_q.push_back(e);
        #1;
    endtask

    // A plain cycle with no rst, clear or load.
    task automatic run(input string name, input logic en, input logic [3:0] e_cnt,
                       input logic e_flag, input logic e_wrap, input logic e_done);
        apply_stimulus(name, 1'b0, 1'b0, 1'b0, 4'd0, en, e_cnt, e_flag, e_wrap, e_done);
    endtask

    task automatic set_mode(input logic dir, input logic os, input logic [3:0] rv,
                            input logic [3:0] pv);
        count_dir    = dir;
        oneshot      = os;
        rollover_val = rv;
        prescale_val = pv;
    endtask

    task automatic check_output(input exp_t e);
        n_vec++;
        if (count_out !== e.cnt || rollover_flag !== e.flag ||
            wrap_pulse !== e.wrap || done !== e.dn) begin
            n_err++;
            $display("[TB] FAIL %s: got cnt=%0d flag=%b wrap=%b done=%b, expected cnt=%0d flag=%b wrap=%b done=%b",
                     e.name, count_out, rollover_flag, wrap_pulse, done,
                     e.cnt, e.flag, e.wrap, e.dn);
        end
    endtask

    // Monitor: each expected entry is checked on the falling edge after its edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_output(cur);
        end
    end

    initial begin
        set_mode(1'b0, 1'b0, 4'd5, 4'd0);
        apply_stimulus("reset", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Up wrap, rollover_val=5
        run("up1", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        run("up2", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("up3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        run("up4", 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        run("up5_flag", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        run("up_wrap", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        run("up_hold", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

        // Down wrap, rollover_val=4, from a load of 3
        set_mode(1'b1, 1'b0, 4'd4, 4'd0);
        apply_stimulus("dn_load3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        run("dn2", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("dn1_flag", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        run("dn_wrap", 1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
        run("dn3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);

        // Down step from above range jumps to rollover_val as a wrap
        set_mode(1'b1, 1'b0, 4'd5, 4'd0);
        apply_stimulus("dn_load9", 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        run("dn_above", 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);

        // Prescale: step every 3 enabled cycles
        set_mode(1'b0, 1'b0, 4'd15, 4'd2);
        apply_stimulus("ps_clear", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        run("ps_c1", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        run("ps_c2", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        run("ps_c3", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        run("ps_c4", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        run("ps_gap", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        run("ps_c5", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        run("ps_c6", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("ps_c7", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("ps_c8", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("ps_c9", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);

        // One-shot, rollover_val=3
        set_mode(1'b0, 1'b1, 4'd3, 4'd0);
        apply_stimulus("os_clear", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        run("os1", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        run("os2", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("os3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        run("os_done", 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
        run("os_sticky", 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
        apply_stimulus("os_load0", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        run("os_resume", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);

        // Priority
        set_mode(1'b0, 1'b0, 4'd5, 4'd0);
        apply_stimulus("pri_clr_ld", 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus("pri_ld_step", 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        apply_stimulus("pri_load9", 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        run("pri_wrap9", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);

        // Reset mid-run with done set
        set_mode(1'b0, 1'b1, 4'd4, 4'd0);
        apply_stimulus("rr_clear", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        run("rr1", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        run("rr2", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        run("rr3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        run("rr4", 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        run("rr_done", 1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
        apply_stimulus("rr_reset", 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

        // rollover_val=0 suppresses stepping
        set_mode(1'b0, 1'b0, 4'd0, 4'd0);
        apply_stimulus("z_clear", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        run("z_hold0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus("z_load3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        run("z_hold3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("[TB] FAIL drain: %0d entries unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
